// File: rtl/xgmii_pkg.sv
// XGMII shared constants, link-status encoding and column classifier.
// Latency: n/a (package only).
// Backpressure: n/a; XGMII runs at line rate with no flow control.
package xgmii_pkg;

    localparam logic [63:0] XGMII_IDLE_D   = 64'h0707070707070707;
    localparam logic [7:0]  XGMII_IDLE_C   = 8'hFF;
    localparam logic [63:0] XGMII_ERROR_D  = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [7:0]  XGMII_ERROR_C  = 8'hFF;
    localparam logic [7:0]  XGMII_START    = 8'hFB;
    localparam logic [7:0]  XGMII_TERM     = 8'hFD;
    localparam logic [7:0]  XGMII_SEQ      = 8'h9C;
    localparam logic [7:0]  XGMII_LF_CODE  = 8'h01;
    localparam logic [7:0]  XGMII_RF_CODE  = 8'h02;

    // Remote-fault ordered set in both columns of a word.
    localparam logic [63:0] XGMII_RF_SET_D = 64'h0200009C0200009C;
    localparam logic [7:0]  XGMII_RF_SET_C = 8'h11;

    typedef enum logic [1:0] {
        LINK_OK = 2'b00,
        LINK_LF = 2'b01,
        LINK_RF = 2'b10
    } link_status_t;

    typedef enum logic [1:0] {
        COL_NONE = 2'b00,
        COL_LF   = 2'b01,
        COL_RF   = 2'b10
    } col_kind_t;

    // A fault sequence column is ||Q|| 00 00 code with only lane 0 as control.
    function automatic col_kind_t classify_col(input logic [31:0] d, input logic [3:0] c);
        if (c == 4'b0001 && d[7:0] == XGMII_SEQ && d[15:8] == 8'h00 && d[23:16] == 8'h00) begin
            if (d[31:24] == XGMII_LF_CODE) return COL_LF;
            if (d[31:24] == XGMII_RF_CODE) return COL_RF;
        end
        return COL_NONE;
    endfunction

endpackage

// File: rtl/xgmii_fault_detect.sv
// Link-fault sequence detector: counts same-type fault columns inside a window.
// Latency: status_next is combinational from the word; status is registered (1 cycle).
// Backpressure: none; one 64-bit word (two columns) consumed every cycle.
// Ports: clk, rst_n, rx_d/rx_c (deinterleaved word), status (registered), status_next.
module xgmii_fault_detect
    import xgmii_pkg::*;
#(
    parameter int FAULT_THRESH = 4,
    parameter int WINDOW       = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [63:0]  rx_d,
    input  logic [7:0]   rx_c,
    output link_status_t status,
    output link_status_t status_next
);

    localparam int SEQ_W = $clog2(FAULT_THRESH + 1);
    localparam int COL_W = $clog2(WINDOW + 1);

    typedef struct packed {
        link_status_t     seq_type;
        logic [SEQ_W-1:0] seq_cnt;
        logic [COL_W-1:0] col_cnt;
        link_status_t     status;
    } det_state_t;

    // One column's worth of state update; applied to column 0 then column 1.
    function automatic det_state_t col_step(input det_state_t s, input col_kind_t kind);
        det_state_t   n;
        link_status_t t;
        n = s;
        if (kind != COL_NONE) begin
            t = (kind == COL_LF) ? LINK_LF : LINK_RF;
            if (t == s.seq_type && s.col_cnt < COL_W'(WINDOW)) begin
                if (s.seq_cnt < SEQ_W'(FAULT_THRESH))
                    n.seq_cnt = s.seq_cnt + 1'b1;
            end else begin
                // Type change, or the previous sequence is too old to chain with.
                n.seq_type = t;
                n.seq_cnt  = SEQ_W'(1);
            end
            n.col_cnt = '0;
            if (n.seq_cnt == SEQ_W'(FAULT_THRESH))
                n.status = t;
        end else if (s.col_cnt < COL_W'(WINDOW)) begin
            n.col_cnt = s.col_cnt + 1'b1;
            if (n.col_cnt == COL_W'(WINDOW)) begin
                n.seq_cnt = '0;
                n.status  = LINK_OK;
            end
        end
        return n;
    endfunction

    det_state_t cur;
    det_state_t mid;
    det_state_t nxt;

    always_comb begin
        mid = col_step(cur, classify_col(rx_d[31:0],  rx_c[3:0]));
        nxt = col_step(mid, classify_col(rx_d[63:32], rx_c[7:4]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur.seq_type <= LINK_LF;
            cur.seq_cnt  <= '0;
            cur.col_cnt  <= '0;
            cur.status   <= LINK_LF;   // pessimistic until the link proves clean
        end else begin
            cur <= nxt;
        end
    end

    assign status      = cur.status;
    assign status_next = nxt.status;

endmodule

// File: rtl/xgmii_rs_fault.sv
// Reconciliation-sublayer link-fault stage: detects LF/RF, masks RX, overrides TX.
// Latency: 1 cycle on both RX and TX paths; status registered with the outputs.
// Backpressure: none; line-rate XGMII, one word per cycle in and out.
// Ports: rx_xgmii_* -> rx_out_* (to MAC), tx_in_* -> tx_out_* (to PHY),
//        link_status/link_up, fault-entry counters with synchronous clear_cnt.
module xgmii_rs_fault
    import xgmii_pkg::*;
#(
    parameter int FAULT_THRESH = 4,
    parameter int WINDOW       = 128,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      rx_xgmii_d,
    input  logic [7:0]       rx_xgmii_c,
    output logic [63:0]      rx_out_d,
    output logic [7:0]       rx_out_c,
    input  logic [63:0]      tx_in_d,
    input  logic [7:0]       tx_in_c,
    output logic [63:0]      tx_out_d,
    output logic [7:0]       tx_out_c,
    output logic [1:0]       link_status,
    output logic             link_up,
    input  logic             clear_cnt,
    output logic [CNT_W-1:0] local_fault_cnt,
    output logic [CNT_W-1:0] remote_fault_cnt
);

    link_status_t status;
    link_status_t status_next;

    xgmii_fault_detect #(
        .FAULT_THRESH (FAULT_THRESH),
        .WINDOW       (WINDOW)
    ) u_detect (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_d        (rx_xgmii_d),
        .rx_c        (rx_xgmii_c),
        .status      (status),
        .status_next (status_next)
    );

    assign link_status = status;

    // Frame tracking on the MAC's TX stream; the last start/terminate in byte
    // order wins, so a start followed by a terminate in one word nets to idle.
    logic tx_in_frame;
    logic frame_next;

    always_comb begin
        frame_next = tx_in_frame;
        for (int k = 0; k < 8; k++) begin
            if (tx_in_c[k] && tx_in_d[8*k +: 8] == XGMII_START && (k == 0 || k == 4))
                frame_next = 1'b1;
            if (tx_in_c[k] && tx_in_d[8*k +: 8] == XGMII_TERM)
                frame_next = 1'b0;
        end
    end

    logic entering_fault;
    logic leaving_ok;

    assign entering_fault = (status_next != LINK_OK) && (status_next != status);
    assign leaving_ok     = (status == LINK_OK) && (status_next != LINK_OK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            local_fault_cnt  <= '0;
            remote_fault_cnt <= '0;
        end else if (clear_cnt) begin
            local_fault_cnt  <= '0;
            remote_fault_cnt <= '0;
        end else if (entering_fault) begin
            if (status_next == LINK_LF && local_fault_cnt != {CNT_W{1'b1}})
                local_fault_cnt <= local_fault_cnt + 1'b1;
            if (status_next == LINK_RF && remote_fault_cnt != {CNT_W{1'b1}})
                remote_fault_cnt <= remote_fault_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_out_d    <= XGMII_IDLE_D;
            rx_out_c    <= XGMII_IDLE_C;
            tx_out_d    <= XGMII_IDLE_D;
            tx_out_c    <= XGMII_IDLE_C;
            link_up     <= 1'b0;
            tx_in_frame <= 1'b0;
        end else begin
            link_up <= (status_next == LINK_OK);

            if (status_next == LINK_OK) begin
                rx_out_d <= rx_xgmii_d;
                rx_out_c <= rx_xgmii_c;
            end else begin
                rx_out_d <= XGMII_IDLE_D;
                rx_out_c <= XGMII_IDLE_C;
            end

            // A frame already partly sent to the PHY is poisoned so the far end
            // drops it instead of seeing a truncated good frame.
            if (leaving_ok && tx_in_frame) begin
                tx_out_d <= XGMII_ERROR_D;
                tx_out_c <= XGMII_ERROR_C;
            end else begin
                case (status_next)
                    LINK_OK: begin
                        tx_out_d <= tx_in_d;
                        tx_out_c <= tx_in_c;
                    end
                    LINK_LF: begin
                        tx_out_d <= XGMII_RF_SET_D;
                        tx_out_c <= XGMII_RF_SET_C;
                    end
                    default: begin
                        tx_out_d <= XGMII_IDLE_D;
                        tx_out_c <= XGMII_IDLE_C;
                    end
                endcase
            end

            tx_in_frame <= leaving_ok ? 1'b0 : frame_next;
        end
    end

endmodule

// File: tb/tb_xgmii_rs_fault.sv
// Directed bench for xgmii_rs_fault: fault declare/clear, TX override, counters.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_xgmii_rs_fault;

    localparam int CNT_W = 3;

    localparam logic [63:0] IDLE_D = 64'h0707070707070707;
    localparam logic [7:0]  IDLE_C = 8'hFF;
    localparam logic [63:0] LF2_D  = 64'h0100009C0100009C;
    localparam logic [63:0] RF2_D  = 64'h0200009C0200009C;
    localparam logic [63:0] RF0_D  = 64'h070707070200009C;
    localparam logic [63:0] ALT_D  = 64'h0200009C0100009C;
    localparam logic [63:0] ERR_D  = 64'hFEFEFEFEFEFEFEFE;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [63:0]      rx_xgmii_d;
    logic [7:0]       rx_xgmii_c;
    logic [63:0]      rx_out_d;
    logic [7:0]       rx_out_c;
    logic [63:0]      tx_in_d;
    logic [7:0]       tx_in_c;
    logic [63:0]      tx_out_d;
    logic [7:0]       tx_out_c;
    logic [1:0]       link_status;
    logic             link_up;
    logic             clear_cnt;
    logic [CNT_W-1:0] local_fault_cnt;
    logic [CNT_W-1:0] remote_fault_cnt;

    int errors = 0;
    int checks = 0;

    xgmii_rs_fault #(.FAULT_THRESH(4), .WINDOW(128), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rx_xgmii_d       (rx_xgmii_d),
        .rx_xgmii_c       (rx_xgmii_c),
        .rx_out_d         (rx_out_d),
        .rx_out_c         (rx_out_c),
        .tx_in_d          (tx_in_d),
        .tx_in_c          (tx_in_c),
        .tx_out_d         (tx_out_d),
        .tx_out_c         (tx_out_c),
        .link_status      (link_status),
        .link_up          (link_up),
        .clear_cnt        (clear_cnt),
        .local_fault_cnt  (local_fault_cnt),
        .remote_fault_cnt (remote_fault_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [63:0] d, input logic [7:0] c);
        rx_xgmii_d = d;
        rx_xgmii_c = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        clear_cnt  = 1'b0;
        rx_xgmii_d = IDLE_D;
        rx_xgmii_c = IDLE_C;
        tx_in_d    = 64'h1111111111111111;
        tx_in_c    = 8'h00;

        // Reset state
        #12;
        chk("rst_status",  64'(link_status), 64'h1);
        chk("rst_link_up", 64'(link_up), 64'h0);
        chk("rst_rx_d",    rx_out_d, IDLE_D);
        chk("rst_rx_c",    64'(rx_out_c), 64'(IDLE_C));
        chk("rst_tx_d",    tx_out_d, IDLE_D);
        chk("rst_lf_cnt",  64'(local_fault_cnt), 64'h0);
        chk("rst_rf_cnt",  64'(remote_fault_cnt), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 63 idle words: still local fault, TX sends remote-fault sets
        repeat (63) step(IDLE_D, IDLE_C);
        chk("w63_status", 64'(link_status), 64'h1);
        chk("w63_link_up", 64'(link_up), 64'h0);
        chk("w63_tx_d", tx_out_d, RF2_D);
        chk("w63_tx_c", 64'(tx_out_c), 64'h11);
        // 64th word completes 128 clean columns
        step(IDLE_D, IDLE_C);
        chk("w64_status", 64'(link_status), 64'h0);
        chk("w64_link_up", 64'(link_up), 64'h1);
        chk("w64_lf_cnt", 64'(local_fault_cnt), 64'h0);
        chk("w64_tx_d", tx_out_d, 64'h1111111111111111);
        // Pass-through of data
        tx_in_d = 64'h2222222222222222;
        step(64'h0123456789ABCDEF, 8'h00);
        chk("ok_rx_d", rx_out_d, 64'h0123456789ABCDEF);
        chk("ok_rx_c", 64'(rx_out_c), 64'h0);
        chk("ok_tx_d", tx_out_d, 64'h2222222222222222);

        // Two words of LF in both columns
        step(LF2_D, 8'h11);
        chk("lf1_status", 64'(link_status), 64'h0);
        chk("lf1_rx_d", rx_out_d, LF2_D);
        step(LF2_D, 8'h11);
        chk("lf2_status", 64'(link_status), 64'h1);
        chk("lf2_link_up", 64'(link_up), 64'h0);
        chk("lf2_lf_cnt", 64'(local_fault_cnt), 64'h1);
        chk("lf2_rx_d", rx_out_d, IDLE_D);
        chk("lf2_rx_c", 64'(rx_out_c), 64'(IDLE_C));
        chk("lf2_tx_d", tx_out_d, RF2_D);
        chk("lf2_tx_c", 64'(tx_out_c), 64'h11);
        repeat (64) step(IDLE_D, IDLE_C);
        chk("lf_clear_status", 64'(link_status), 64'h0);

        // RF in column 0 every 20 words: declared on the 4th
        repeat (3) begin
            step(RF0_D, 8'hF1);
            repeat (19) step(IDLE_D, IDLE_C);
        end
        chk("rf20_pre_status", 64'(link_status), 64'h0);
        step(RF0_D, 8'hF1);
        chk("rf20_status", 64'(link_status), 64'h2);
        chk("rf20_rf_cnt", 64'(remote_fault_cnt), 64'h1);
        chk("rf20_lf_cnt", 64'(local_fault_cnt), 64'h1);
        chk("rf20_tx_d", tx_out_d, IDLE_D);
        chk("rf20_tx_c", 64'(tx_out_c), 64'(IDLE_C));
        repeat (64) step(IDLE_D, IDLE_C);
        chk("rf_clear_status", 64'(link_status), 64'h0);

        // RF every 70 words: window expires between sequences
        repeat (3) begin
            step(RF0_D, 8'hF1);
            repeat (69) step(IDLE_D, IDLE_C);
        end
        step(RF0_D, 8'hF1);
        chk("rf70_status", 64'(link_status), 64'h0);
        chk("rf70_rf_cnt", 64'(remote_fault_cnt), 64'h1);
        chk("rf70_rx_d", rx_out_d, RF0_D);

        // Alternating LF/RF columns never chain
        repeat (4) step(ALT_D, 8'h11);
        chk("alt_status", 64'(link_status), 64'h0);
        chk("alt_lf_cnt", 64'(local_fault_cnt), 64'h1);

        // Fault declared while the MAC is mid-frame
        tx_in_d = 64'h55555555555555FB;
        tx_in_c = 8'h01;
        step(IDLE_D, IDLE_C);
        chk("mf_start_tx_d", tx_out_d, 64'h55555555555555FB);
        chk("mf_start_tx_c", 64'(tx_out_c), 64'h01);
        tx_in_d = 64'hAAAAAAAAAAAAAAAA;
        tx_in_c = 8'h00;
        step(IDLE_D, IDLE_C);
        step(LF2_D, 8'h11);
        chk("mf_data_tx_d", tx_out_d, 64'hAAAAAAAAAAAAAAAA);
        step(LF2_D, 8'h11);
        chk("mf_err_tx_d", tx_out_d, ERR_D);
        chk("mf_err_tx_c", 64'(tx_out_c), 64'hFF);
        chk("mf_status", 64'(link_status), 64'h1);
        chk("mf_lf_cnt", 64'(local_fault_cnt), 64'h2);
        step(IDLE_D, IDLE_C);
        chk("mf_rfset_tx_d", tx_out_d, RF2_D);
        chk("mf_rfset_tx_c", 64'(tx_out_c), 64'h11);

        // Direct LF<->RF transitions drive the counters toward saturation
        repeat (4) begin
            step(RF2_D, 8'h11);
            step(RF2_D, 8'h11);
            step(LF2_D, 8'h11);
            step(LF2_D, 8'h11);
        end
        chk("sat_lf_pre", 64'(local_fault_cnt), 64'h6);
        chk("sat_rf_pre", 64'(remote_fault_cnt), 64'h5);
        repeat (2) begin
            step(RF2_D, 8'h11);
            step(RF2_D, 8'h11);
            step(LF2_D, 8'h11);
            step(LF2_D, 8'h11);
        end
        chk("sat_lf", 64'(local_fault_cnt), 64'h7);
        chk("sat_rf", 64'(remote_fault_cnt), 64'h7);
        chk("sat_status", 64'(link_status), 64'h1);

        // clear_cnt wins over a simultaneous entry into RF
        step(RF2_D, 8'h11);
        clear_cnt = 1'b1;
        step(RF2_D, 8'h11);
        clear_cnt = 1'b0;
        chk("clr_status", 64'(link_status), 64'h2);
        chk("clr_rf_cnt", 64'(remote_fault_cnt), 64'h0);
        chk("clr_lf_cnt", 64'(local_fault_cnt), 64'h0);
        step(LF2_D, 8'h11);
        step(LF2_D, 8'h11);
        chk("post_clr_lf_cnt", 64'(local_fault_cnt), 64'h1);
        chk("post_clr_tx_d", tx_out_d, RF2_D);

        // Asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_status", 64'(link_status), 64'h1);
        chk("arst_tx_d", tx_out_d, IDLE_D);
        chk("arst_tx_c", 64'(tx_out_c), 64'(IDLE_C));
        chk("arst_rx_d", rx_out_d, IDLE_D);
        chk("arst_lf_cnt", 64'(local_fault_cnt), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
